param_bubble_sort: RTL and testbench

Parametrised in-place bubble sorter with an internal register-file memory. A host loads DEPTH unsigned words through a load port, pulses `start`, and the block sorts them ascending or descending. The block pulses `done` when sorting is finished, and the sorted contents are then read back through a registered read port. It generalises the fixed 8-bit/32-entry sorter in the datapath library with the following additions:
- width, depth and direction are configurable;
- a swap counter reports how many exchanges the last sort made;
- an optional early-exit pass check ends the sort early on already-ordered data.

---
 rtl/param_bubble_sort.sv | 96 +++++++++
 tb/tb_param_bubble_sort.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/param_bubble_sort.sv
// param_bubble_sort: in-place bubble sorter over an internal register file; SORT_EARLY_EXIT_EN enables the sorted-pass early exit.
module param_bubble_sort #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              desc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_cnt
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DN} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r1, r2;
  logic [ADDR_W-1:0] p, j;
  logic desc_q, swap_req, pass_end, last_p, adv, early_stop, go, ld_ok, rd_ok;
  assign go = state == IDLE && start;
  assign ld_ok = {1'b0, ld_addr} < (ADDR_W+1)'(DEPTH);
  assign rd_ok = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
  assign busy = state != IDLE;
  assign done = state == DN;
`ifdef SORT_EARLY_EXIT_EN
  logic flag;
  always_ff @(posedge clk) begin
    if (rst) flag <= 1'b0;
    else if (go || (adv && pass_end)) flag <= 1'b0;
    else if (state == WR_B) flag <= 1'b1;
  end
  // A pass that reaches its end from CMP with no swap so far leaves the array ordered.
  assign early_stop = state == CMP && !flag;
`else
  assign early_stop = 1'b0;
`endif
  always_comb begin
    swap_req = desc_q ? (r1 < r2) : (r1 > r2);
    pass_end = (j + p) == ADDR_W'(DEPTH - 2);
    last_p   = p == ADDR_W'(DEPTH - 2);
    adv      = (state == CMP && !swap_req) || state == WR_B;
    nxt      = state;
    case (state)
      IDLE:    nxt = start ? RD_A : IDLE;
      RD_A:    nxt = RD_B;
      RD_B:    nxt = CMP;
      WR_A:    nxt = WR_B;
      DN:      nxt = IDLE;
      default: nxt = (state == CMP && swap_req) ? WR_A
                   : (pass_end && (last_p || early_stop)) ? DN : RD_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p        <= '0;
      j        <= '0;
      r1       <= '0;
      r2       <= '0;
      desc_q   <= 1'b0;
      swap_cnt <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        desc_q   <= desc;
        p        <= '0;
        j        <= '0;
        swap_cnt <= '0;
      end
      if (state == RD_A) r1 <= mem[j];
      if (state == RD_B) r2 <= mem[j + 1'b1];
      if (state == WR_B && !(&swap_cnt)) swap_cnt <= swap_cnt + 1'b1;
      if (adv && nxt == RD_A) begin
        p <= pass_end ? p + 1'b1 : p;
        j <= pass_end ? '0 : j + 1'b1;
      end
    end
  end
  // Storage has no reset so a mid-sort reset leaves partially sorted data in place.
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_en && ld_ok) mem[ld_addr] <= ld_data;
    else if (state == WR_A) mem[j] <= r2;
    else if (state == WR_B) mem[j + 1'b1] <= r1;
  end
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else rd_data <= rd_ok ? mem[rd_addr] : '0;
  end
endmodule

// File: tb/tb_param_bubble_sort.sv
// tb_param_bubble_sort: table-driven sort vectors with a readback scoreboard, plus reset and load/start corner sequences.
module tb_param_bubble_sort;
  localparam int W = 8, D = 4, C = 16, A = 2;
  logic clk = 0, rst = 1, start = 0, desc = 0, ld_en = 0;
  logic [A-1:0] ld_addr = '0, rd_addr = '0;
  logic [W-1:0] ld_data = '0, rd_data;
  logic busy, done;
  logic [C-1:0] swap_cnt;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] cur [D];
  logic [W-1:0] q [$];
  typedef struct {
    logic [W-1:0] d [D];
    logic [W-1:0] e [D];
    logic dsc;
    bit poke;
    int swaps;
    int cyc;
  } vec_t;
  vec_t tbl [4];
  param_bubble_sort #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .start(start), .desc(desc), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .swap_cnt(swap_cnt));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load_start(input logic dsc);
    for (int i = 0; i < D; i++) begin
      ld_en = 1; ld_addr = A'(i); ld_data = cur[i];
      tick();
    end
    ld_en = 0; start = 1; desc = dsc;
    tick();
    start = 0; desc = ~dsc;
  endtask
  task automatic wait_done(input bit poke, output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      ld_en = poke; ld_addr = '0; ld_data = 8'hAA;
      tick();
      cyc++;
    end
    ld_en = 0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: done not seen within %0d cycles", cyc);
    end
    tick();
    check("done_one_pulse", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
  endtask
  task automatic readback(input string name);
    for (int i = 0; i < D; i++) begin
      rd_addr = A'(i);
      tick();
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s: scoreboard empty at addr %0d", name, i);
      end else check(name, int'(rd_data), int'(q.pop_front()));
    end
  endtask
  initial begin
    int cyc;
    tbl[0].d = '{8'd9, 8'd3, 8'd7, 8'd1}; tbl[0].e = '{8'd1, 8'd3, 8'd7, 8'd9};
    tbl[0].dsc = 0; tbl[0].poke = 0; tbl[0].swaps = 5; tbl[0].cyc = 29;
    tbl[1].d = '{8'd1, 8'd2, 8'd3, 8'd4}; tbl[1].e = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[1].dsc = 0; tbl[1].poke = 0; tbl[1].swaps = 0;
`ifdef SORT_EARLY_EXIT_EN
    tbl[1].cyc = 10;
`else
    tbl[1].cyc = 19;
`endif
    tbl[2].d = '{8'd1, 8'd2, 8'd3, 8'd4}; tbl[2].e = '{8'd4, 8'd3, 8'd2, 8'd1};
    tbl[2].dsc = 1; tbl[2].poke = 0; tbl[2].swaps = 6; tbl[2].cyc = 31;
    tbl[3].d = '{8'd5, 8'd5, 8'd2, 8'd5}; tbl[3].e = '{8'd2, 8'd5, 8'd5, 8'd5};
    tbl[3].dsc = 0; tbl[3].poke = 1; tbl[3].swaps = 2; tbl[3].cyc = 23;
    tick(); tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_swap_cnt", int'(swap_cnt), 0);
    check("reset_rd_data", int'(rd_data), 0);
    rst = 0;
    tick();
    for (int v = 0; v < 4; v++) begin
      cur = tbl[v].d;
      load_start(tbl[v].dsc);
      check("busy_after_start", int'(busy), 1);
      for (int i = 0; i < D; i++) q.push_back(tbl[v].e[i]);
      wait_done(tbl[v].poke, cyc);
      check("done_cycle", cyc, tbl[v].cyc);
      check("swap_cnt", int'(swap_cnt), tbl[v].swaps);
      readback("sorted_word");
    end
    // reset 7 cycles into a sort, then resort the partially sorted memory
    cur = '{8'd4, 8'd3, 8'd2, 8'd1};
    load_start(1'b0);
    for (int i = 1; i < 7; i++) begin
      check("no_done_before_rst", int'(done), 0);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    start = 1; desc = 0;
    tick();
    start = 0;
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    wait_done(0, cyc);
    check("rst_resort_cycle", cyc, 29);
    check("rst_resort_swaps", int'(swap_cnt), 5);
    readback("rst_resort_word");
    // load and start in the same cycle: the new value takes part in the sort
    cur = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < D; i++) begin
      ld_en = 1; ld_addr = A'(i); ld_data = cur[i];
      tick();
    end
    ld_addr = '0; ld_data = 8'hFF; start = 1; desc = 0;
    tick();
    ld_en = 0; start = 0;
    q.push_back(8'd2); q.push_back(8'd3); q.push_back(8'd4); q.push_back(8'hFF);
    wait_done(0, cyc);
    check("ldstart_swaps", int'(swap_cnt), 3);
    check("ldstart_swap_cnt_held", int'(swap_cnt), 3);
    readback("ldstart_word");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
